// File: rtl/uart_cmd_seq.sv
// uart_cmd_seq: command sequencer between uart_ctrl and a memory port.
// Parses byte packets from UART RX and runs one memory access per packet.
// It answers with a single byte through UART TX.
//   Write packet: 8'h57, ADDR_BYTES address bytes (MSB first), one data byte -> ACK_BYTE
//   Read packet : 8'h52, ADDR_BYTES address bytes (MSB first)                -> read data
//   Bad opcode or RX error -> NAK_BYTE; inter-byte silence -> abort with oTimeout.
// Ports:
//   iClock, iReset            : clock, synchronous active-high reset
//   iRxByte/iRxReady/iRxError : RX byte, byte strobe, framing-error strobe
//   oTxByte/oTxReady/iTxSent  : TX byte, one-cycle send request, stop-bit-done strobe
//   oMemAddr/oMemData         : memory address / write data
//   oMemWrEn/oMemRdEn         : access requests, held until the cycle after iMemAck
//   iMemData/iMemAck          : read data and acknowledge
//   oBusy/oTimeout/oOverrun   : not-idle flag, timeout pulse, dropped-byte pulse
module uart_cmd_seq #(
    parameter int          ADDR_WIDTH     = 16,
    parameter int          TIMEOUT_CYCLES = 32000,
    parameter int          TIMEOUT_BITS   = 16,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic [7:0]            iRxByte,
    input  logic                  iRxReady,
    input  logic                  iRxError,
    output logic [7:0]            oTxByte,
    output logic                  oTxReady,
    input  logic                  iTxSent,
    output logic [ADDR_WIDTH-1:0] oMemAddr,
    output logic [7:0]            oMemData,
    output logic                  oMemWrEn,
    output logic                  oMemRdEn,
    input  logic [7:0]            iMemData,
    input  logic                  iMemAck,
    output logic                  oBusy,
    output logic                  oTimeout,
    output logic                  oOverrun
);
    localparam int ADDR_BYTES = ADDR_WIDTH / 8;
    localparam int CW         = $clog2(ADDR_BYTES + 1);
    localparam logic [CW-1:0]           ACNT_LAST = CW'(ADDR_BYTES - 1);
    localparam logic [TIMEOUT_BITS-1:0] TMO_LAST  = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] OP_WR = 8'h57;
    localparam logic [7:0] OP_RD = 8'h52;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_MEM_WR, S_MEM_RD, S_TX_SEND, S_TX_WAIT
    } state_t;

    state_t                  r_state,   w_state_nxt;
    logic                    r_op_wr,   w_op_wr_nxt;
    logic [CW-1:0]           r_acnt,    w_acnt_nxt;
    logic [TIMEOUT_BITS-1:0] r_tmo,     w_tmo_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr,    w_addr_nxt;
    logic [7:0]              r_wdata,   w_wdata_nxt;
    logic [7:0]              r_txbyte,  w_txbyte_nxt;
    logic                    r_txready, w_txready_nxt;
    logic                    r_wren,    w_wren_nxt;
    logic                    r_rden,    w_rden_nxt;
    logic                    r_busy;
    logic                    r_timeout, w_timeout_nxt;
    logic                    r_overrun, w_overrun_nxt;
    logic [ADDR_WIDTH-1:0]   w_addr_shift;

    // New address byte enters at the LSB end; older bytes move up.
    if (ADDR_WIDTH > 8) begin : g_wide
        assign w_addr_shift = {r_addr[ADDR_WIDTH-9:0], iRxByte};
    end else begin : g_narrow
        assign w_addr_shift = iRxByte;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_op_wr_nxt   = r_op_wr;
        w_acnt_nxt    = r_acnt;
        w_tmo_nxt     = r_tmo;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_txbyte_nxt  = r_txbyte;
        w_txready_nxt = 1'b0;
        w_wren_nxt    = r_wren;
        w_rden_nxt    = r_rden;
        w_timeout_nxt = 1'b0;
        w_overrun_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (iRxError) begin
                    w_state_nxt   = S_TX_SEND;
                    w_txbyte_nxt  = NAK_BYTE;
                    w_txready_nxt = 1'b1;
                end else if (iRxReady) begin
                    if (iRxByte == OP_WR || iRxByte == OP_RD) begin
                        w_state_nxt = S_ADDR;
                        w_op_wr_nxt = (iRxByte == OP_WR);
                        w_acnt_nxt  = '0;
                        w_tmo_nxt   = '0;
                    end else begin
                        w_state_nxt   = S_TX_SEND;
                        w_txbyte_nxt  = NAK_BYTE;
                        w_txready_nxt = 1'b1;
                    end
                end
            end
            S_ADDR, S_DATA: begin
                // Error beats a simultaneous byte; a byte beats the timeout.
                if (iRxError) begin
                    w_state_nxt   = S_TX_SEND;
                    w_txbyte_nxt  = NAK_BYTE;
                    w_txready_nxt = 1'b1;
                    w_tmo_nxt     = '0;
                end else if (iRxReady) begin
                    w_tmo_nxt = '0;
                    if (r_state == S_DATA) begin
                        w_wdata_nxt = iRxByte;
                        w_state_nxt = S_MEM_WR;
                        w_wren_nxt  = 1'b1;
                    end else begin
                        w_addr_nxt = w_addr_shift;
                        w_acnt_nxt = r_acnt + CW'(1);
                        if (r_acnt == ACNT_LAST) begin
                            if (r_op_wr) begin
                                w_state_nxt = S_DATA;
                            end else begin
                                w_state_nxt = S_MEM_RD;
                                w_rden_nxt  = 1'b1;
                            end
                        end
                    end
                end else if (r_tmo == TMO_LAST) begin
                    w_state_nxt   = S_IDLE;
                    w_timeout_nxt = 1'b1;
                    w_tmo_nxt     = '0;
                end else begin
                    w_tmo_nxt = r_tmo + TIMEOUT_BITS'(1);
                end
            end
            S_MEM_WR, S_MEM_RD: begin
                w_overrun_nxt = iRxReady | iRxError;
                if (iMemAck && (r_wren || r_rden)) begin
                    w_wren_nxt    = 1'b0;
                    w_rden_nxt    = 1'b0;
                    w_state_nxt   = S_TX_SEND;
                    w_txready_nxt = 1'b1;
                    w_txbyte_nxt  = (r_state == S_MEM_WR) ? ACK_BYTE : iMemData;
                end
            end
            S_TX_SEND: begin
                w_overrun_nxt = iRxReady | iRxError;
                w_state_nxt   = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                w_overrun_nxt = iRxReady | iRxError;
                if (iTxSent) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_state   <= S_IDLE;
            r_op_wr   <= 1'b0;
            r_acnt    <= '0;
            r_tmo     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_txbyte  <= '0;
            r_txready <= 1'b0;
            r_wren    <= 1'b0;
            r_rden    <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_op_wr   <= w_op_wr_nxt;
            r_acnt    <= w_acnt_nxt;
            r_tmo     <= w_tmo_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_txbyte  <= w_txbyte_nxt;
            r_txready <= w_txready_nxt;
            r_wren    <= w_wren_nxt;
            r_rden    <= w_rden_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_timeout <= w_timeout_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    assign oTxByte  = r_txbyte;
    assign oTxReady = r_txready;
    assign oMemAddr = r_addr;
    assign oMemData = r_wdata;
    assign oMemWrEn = r_wren;
    assign oMemRdEn = r_rden;
    assign oBusy    = r_busy;
    assign oTimeout = r_timeout;
    assign oOverrun = r_overrun;
endmodule
